// File: rtl/fifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_if
//   Bundles the two producer handshakes and the FIFO write port that the
//   fifo_write_arbiter sits between.
//
//   Signals (directions as seen by the arbiter, i.e. the slave modport):
//     Req0_In / Data0_In    in   producer 0 valid beat and its data
//     Ack0_Out              out  producer 0 beat written this cycle
//     Req1_In / Data1_In    in   producer 1 valid beat and its data
//     Ack1_Out              out  producer 1 beat written this cycle
//     FIFO_Full_In          in   FIFO full flag
//     FIFO_Data_Out         out  data towards the FIFO
//     FIFO_Write_Out        out  FIFO write enable
//     Grant_Out             out  one-hot current grant, 2'b00 when idle
//
//   master : the producers/FIFO side (drives requests, data and full)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  Req0_In;
  logic [DATA_WIDTH-1:0] Data0_In;
  logic                  Ack0_Out;
  logic                  Req1_In;
  logic [DATA_WIDTH-1:0] Data1_In;
  logic                  Ack1_Out;
  logic                  FIFO_Full_In;
  logic [DATA_WIDTH-1:0] FIFO_Data_Out;
  logic                  FIFO_Write_Out;
  logic [1:0]            Grant_Out;

  modport slave (
    input  Req0_In, Data0_In, Req1_In, Data1_In, FIFO_Full_In,
    output Ack0_Out, Ack1_Out, FIFO_Data_Out, FIFO_Write_Out, Grant_Out
  );

  modport master (
    output Req0_In, Data0_In, Req1_In, Data1_In, FIFO_Full_In,
    input  Ack0_Out, Ack1_Out, FIFO_Data_Out, FIFO_Write_Out, Grant_Out
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//   Shares the write port of one FIFO between two producers. Round-robin
//   arbitration with bounded bursts: the granted producer streams up to
//   MAX_BURST beats before the other one (if waiting) takes over. FIFO full
//   stalls the granted producer without giving the grant away.
//
//   Ports:
//     Clk_In    in  clock, rising edge
//     Reset_In  in  synchronous, active-high reset
//     bus       fifo_write_arbiter_if.slave: producer handshakes, FIFO write
//               port and the registered one-hot grant
//
//   A beat is the same-cycle handshake Req_x & ~FIFO_Full_In while granted;
//   write enable, data and Ack are decoded combinationally from the
//   registered grant so a producer can stream one beat per cycle.
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                 Clk_In,
  input  logic                 Reset_In,
  fifo_write_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  // Value of the beat counter on the beat that completes a full burst.
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  // Encoding doubles as the one-hot grant, so Grant_Out is a pure register.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic                  r_last_served;

  logic                  w_beat0;
  logic                  w_beat1;
  logic [DATA_WIDTH-1:0] w_data;

  // Beat decode and FIFO data mux from the registered grant.
  always_comb begin
    w_beat0 = 1'b0;
    w_beat1 = 1'b0;
    w_data  = {DATA_WIDTH{1'b0}};
    if (Reset_In) begin
      // Keep the FIFO and producers quiet while reset is being applied.
      w_beat0 = 1'b0;
      w_beat1 = 1'b0;
      w_data  = {DATA_WIDTH{1'b0}};
    end else begin
      case (r_state)
        GNT0: begin
          w_beat0 = bus.Req0_In & ~bus.FIFO_Full_In;
          w_data  = bus.Data0_In;
        end
        GNT1: begin
          w_beat1 = bus.Req1_In & ~bus.FIFO_Full_In;
          w_data  = bus.Data1_In;
        end
        default: begin
          w_beat0 = 1'b0;
          w_beat1 = 1'b0;
          w_data  = {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign bus.FIFO_Write_Out = w_beat0 | w_beat1;
  assign bus.FIFO_Data_Out  = w_data;
  assign bus.Ack0_Out       = w_beat0;
  assign bus.Ack1_Out       = w_beat1;
  assign bus.Grant_Out      = r_state;

  // Arbitration FSM: grant selection, burst counting and fairness memory.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_state       <= IDLE;
      r_beat_cnt    <= {CNT_W{1'b0}};
      r_last_served <= 1'b1;  // channel 0 wins the first tie
    end else begin
      case (r_state)
        IDLE: begin
          r_beat_cnt <= {CNT_W{1'b0}};
          if (bus.Req0_In && bus.Req1_In) begin
            r_state <= r_last_served ? GNT0 : GNT1;
          end else if (bus.Req0_In) begin
            r_state <= GNT0;
          end else if (bus.Req1_In) begin
            r_state <= GNT1;
          end else begin
            r_state <= IDLE;
          end
        end

        GNT0: begin
          if (!bus.Req0_In) begin
            r_last_served <= 1'b0;
            r_beat_cnt    <= {CNT_W{1'b0}};
            r_state       <= bus.Req1_In ? GNT1 : IDLE;
          end else if (bus.FIFO_Full_In) begin
            // Stalled: counter frozen and grant kept, no switch on full.
            r_beat_cnt <= r_beat_cnt;
          end else if (r_beat_cnt == LAST_BEAT) begin
            r_beat_cnt <= {CNT_W{1'b0}};
            if (bus.Req1_In) begin
              r_last_served <= 1'b0;
              r_state       <= GNT1;
            end else begin
              // Nobody waiting: start a fresh burst on the same channel.
              r_state <= GNT0;
            end
          end else begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1'b1);
          end
        end

        GNT1: begin
          if (!bus.Req1_In) begin
            r_last_served <= 1'b1;
            r_beat_cnt    <= {CNT_W{1'b0}};
            r_state       <= bus.Req0_In ? GNT0 : IDLE;
          end else if (bus.FIFO_Full_In) begin
            r_beat_cnt <= r_beat_cnt;
          end else if (r_beat_cnt == LAST_BEAT) begin
            r_beat_cnt <= {CNT_W{1'b0}};
            if (bus.Req0_In) begin
              r_last_served <= 1'b1;
              r_state       <= GNT0;
            end else begin
              r_state <= GNT1;
            end
          end else begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1'b1);
          end
        end

        default: begin
          r_state    <= IDLE;
          r_beat_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
